// File: rtl/apb_req_master_pkg.sv
// Shared types and constants for the req/gnt to APB initiator bridge.
package apb_req_master_pkg;

    // Transfer sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Wait-state counter width; covers the largest timeout of 255.
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/apb_req_master.sv
// Request/grant/rvalid port to APB initiator bridge, one transfer in flight,
// with a wait-state watchdog that aborts transfers to a hung slave.
module apb_req_master
    import apb_req_master_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    // Requester side
    input  logic                      req_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [31:0]               wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [31:0]               rdata_o,
    output logic                      err_o,
    // APB side
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam bit               TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CntLast   = CNT_W'(TIMEOUT_CYCLES - 1);

    apb_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic                      rvalid_q, rvalid_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      err_q, err_d;

    // Next-state for FSM, watchdog counter, APB attributes and response.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rvalid_d = 1'b0;
        rdata_d  = 32'h0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    paddr_d  = addr_i;
                    pwdata_d = wdata_i;
                    pwrite_d = we_i;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                // PREADY takes priority over the watchdog in the same cycle.
                if (PREADY) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b1;
                    rdata_d  = pwrite_q ? 32'h0 : PRDATA;
                    err_d    = PSLVERR;
                end else if (TimeoutEn && (cnt_q == CntLast)) begin
                    // Recovery abort: PSEL drops mid-transfer on purpose.
                    state_d  = IDLE;
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            paddr_q  <= '0;
            pwdata_q <= 32'h0;
            pwrite_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Outputs; grant is gated by reset so it reads 0 while reset is held.
    always_comb begin
        gnt_o    = req_i && (state_q == IDLE) && HRESETn;
        PSEL     = (state_q != IDLE);
        PENABLE  = (state_q == ACCESS);
        PADDR    = paddr_q;
        PWDATA   = pwdata_q;
        PWRITE   = pwrite_q;
        rvalid_o = rvalid_q;
        rdata_o  = rdata_q;
        err_o    = err_q;
    end

endmodule

// File: tb/tb_apb_req_master.sv
// Self-checking bench for apb_req_master: transaction-level model compared every
// negedge, directed scenarios with literal expectations, then random traffic.
module tb_apb_req_master;

    localparam int unsigned AW = 12;
    localparam int unsigned TO = 4;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          req_i = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic          we_i = 1'b0;
    logic [31:0]   wdata_i = 32'h0;
    logic          gnt_o, rvalid_o, err_o;
    logic [31:0]   rdata_o;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE, PSEL, PENABLE;
    logic [31:0]   PRDATA = 32'h0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    int checks = 0;
    int failures = 0;

    apb_req_master #(
        .APB_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .req_i    (req_i),
        .addr_i   (addr_i),
        .we_i     (we_i),
        .wdata_i  (wdata_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Transaction model: a transfer is "busy" from the grant edge; age 1 is the
    // setup cycle, age n>=2 is access cycle number n-1.
    bit          m_busy = 0;
    int          m_age = 0;
    logic [AW-1:0] m_addr = '0;
    logic [31:0] m_wdata = 32'h0;
    logic        m_we = 1'b0;
    logic        m_rv = 1'b0;
    logic [31:0] m_rd = 32'h0;
    logic        m_err = 1'b0;

    always @(posedge HCLK or negedge HRESETn) begin
        logic        nrv, nerr;
        logic [31:0] nrd;
        if (!HRESETn) begin
            m_busy = 0; m_age = 0; m_addr = '0; m_wdata = 32'h0; m_we = 1'b0;
            m_rv = 1'b0; m_rd = 32'h0; m_err = 1'b0;
        end else begin
            nrv = 1'b0; nrd = 32'h0; nerr = 1'b0;
            if (m_busy) begin
                if (m_age == 1) begin
                    m_age = 2;
                end else if (PREADY) begin
                    m_busy = 0; nrv = 1'b1; nerr = PSLVERR;
                    nrd = m_we ? 32'h0 : PRDATA;
                end else if (TO != 0 && m_age - 1 == int'(TO)) begin
                    m_busy = 0; nrv = 1'b1; nerr = 1'b1;
                end else begin
                    m_age++;
                end
            end else if (req_i) begin
                m_busy = 1; m_age = 1;
                m_addr = addr_i; m_we = we_i; m_wdata = wdata_i;
            end
            m_rv = nrv; m_rd = nrd; m_err = nerr;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge HCLK) begin
        chk("m_gnt", {31'b0, gnt_o}, {31'b0, HRESETn && req_i && !m_busy});
        chk("m_psel", {31'b0, PSEL}, {31'b0, m_busy});
        chk("m_penable", {31'b0, PENABLE}, {31'b0, m_busy && m_age >= 2});
        chk("m_paddr", {20'b0, PADDR}, {20'b0, m_addr});
        chk("m_pwdata", PWDATA, m_wdata);
        chk("m_pwrite", {31'b0, PWRITE}, {31'b0, m_we});
        chk("m_rvalid", {31'b0, rvalid_o}, {31'b0, m_rv});
        chk("m_rdata", rdata_o, m_rd);
        chk("m_err", {31'b0, err_o}, {31'b0, m_err});
    end

    // Issues one transfer; slave answers ready after 'waits' low access cycles.
    task automatic run_xfer(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                            input int waits, input logic [31:0] prdata, input logic slverr,
                            output int gwait, output int lat, output int acc,
                            output logic [31:0] rd, output logic er, output logic stable,
                            output logic psel_at_rv);
        bit done;
        #1;
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
        PSLVERR = slverr; PREADY = 1'b0; PRDATA = ~prdata;
        gwait = 0;
        #1;
        while (!gnt_o && gwait < 50) begin
            @(negedge HCLK); #1;
            gwait++;
        end
        if (!gnt_o) chk("grant_wait", 32'd0, 32'd1);
        @(posedge HCLK); #1;
        req_i = 1'b0;
        lat = 0; acc = 0; stable = 1'b1; rd = 32'h0; er = 1'b0; psel_at_rv = 1'b1; done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge HCLK);
            lat++;
            if (rvalid_o) begin
                rd = rdata_o; er = err_o; psel_at_rv = PSEL; done = 1;
                break;
            end
            if (PENABLE) begin
                acc++;
                if (PADDR !== addr) stable = 1'b0;
            end
            #1;
            PREADY = PENABLE && (acc > waits);
            PRDATA = PREADY ? prdata : ~prdata;
        end
        #1;
        PREADY = 1'b0;
        if (!done) chk("rvalid_wait", 32'd0, 32'd1);
    endtask

    int          gw, lt, ac;
    logic [31:0] rd;
    logic        er, st, ps;
    bit          stuck, gnt_seen;

    initial begin
        #200000;
        $display("FAIL watchdog actual=hang expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Reset values, with a write request already pending.
        req_i = 1'b1; addr_i = 12'h008; we_i = 1'b1; wdata_i = 32'h1234_5678; PREADY = 1'b1;
        #7;
        chk("rst_gnt", {31'b0, gnt_o}, 32'd0);
        chk("rst_psel", {31'b0, PSEL}, 32'd0);
        chk("rst_penable", {31'b0, PENABLE}, 32'd0);
        chk("rst_paddr", {20'b0, PADDR}, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid_o}, 32'd0);
        #5 HRESETn = 1'b1;
        #1 chk("wr_gnt_k", {31'b0, gnt_o}, 32'd1);
        @(posedge HCLK); #1 req_i = 1'b0;
        @(negedge HCLK);
        chk("wr_k1_psel", {31'b0, PSEL}, 32'd1);
        chk("wr_k1_penable", {31'b0, PENABLE}, 32'd0);
        chk("wr_k1_pwrite", {31'b0, PWRITE}, 32'd1);
        chk("wr_k1_paddr", {20'b0, PADDR}, 32'h008);
        chk("wr_k1_pwdata", PWDATA, 32'h1234_5678);
        @(negedge HCLK);
        chk("wr_k2_psel", {31'b0, PSEL}, 32'd1);
        chk("wr_k2_penable", {31'b0, PENABLE}, 32'd1);
        @(negedge HCLK);
        chk("wr_k3_rvalid", {31'b0, rvalid_o}, 32'd1);
        chk("wr_k3_err", {31'b0, err_o}, 32'd0);
        chk("wr_k3_rdata", rdata_o, 32'd0);
        chk("wr_k3_psel", {31'b0, PSEL}, 32'd0);
        PREADY = 1'b0;

        // Read with 3 wait states; ready on the 4th access cycle (watchdog edge).
        run_xfer(1'b0, 12'h0A4, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, gw, lt, ac, rd, er, st, ps);
        chk("rd3_access_cycles", ac, 32'd4);
        chk("rd3_latency", lt, 32'd6);
        chk("rd3_rdata", rd, 32'hDEAD_BEEF);
        chk("rd3_err", {31'b0, er}, 32'd0);
        chk("rd3_paddr_stable", {31'b0, st}, 32'd1);

        // Slave error on a zero-wait read.
        run_xfer(1'b0, 12'h100, 32'h0, 0, 32'hA5A5_0001, 1'b1, gw, lt, ac, rd, er, st, ps);
        chk("slverr_latency", lt, 32'd3);
        chk("slverr_err", {31'b0, er}, 32'd1);
        chk("slverr_rdata", rd, 32'hA5A5_0001);

        // Stuck slave: watchdog abort after exactly 4 access cycles.
        run_xfer(1'b0, 12'h204, 32'h0, 100, 32'h5555_AAAA, 1'b0, gw, lt, ac, rd, er, st, ps);
        chk("to_access_cycles", ac, 32'd4);
        chk("to_latency", lt, 32'd6);
        chk("to_err", {31'b0, er}, 32'd1);
        chk("to_rdata", rd, 32'd0);
        chk("to_psel_low", {31'b0, ps}, 32'd0);
        // Following request is granted in the response cycle.
        run_xfer(1'b1, 12'h208, 32'hCAFE_0001, 0, 32'h0, 1'b0, gw, lt, ac, rd, er, st, ps);
        chk("to_next_gwait", gw, 32'd0);
        chk("to_next_latency", lt, 32'd3);
        chk("to_next_err", {31'b0, er}, 32'd0);

        // Back-to-back zero-wait writes with req held high.
        @(negedge HCLK); #1;
        req_i = 1'b1; we_i = 1'b1; addr_i = 12'h010; wdata_i = 32'h0000_0B2B; PREADY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                @(negedge HCLK); #1;
            end
            #1;
            chk("b2b_gnt", {31'b0, gnt_o}, {31'b0, (i % 3 == 0) && (i < 9)});
            chk("b2b_rvalid", {31'b0, rvalid_o}, {31'b0, (i == 3) || (i == 6) || (i == 9)});
            if (i == 7) req_i = 1'b0;
        end
        PREADY = 1'b0;

        // Reset pulse during ACCESS drops the transfer.
        @(negedge HCLK); #1;
        req_i = 1'b1; we_i = 1'b0; addr_i = 12'h0C0;
        @(posedge HCLK); #1 req_i = 1'b0;
        @(negedge HCLK);
        @(negedge HCLK);
        chk("rstmid_in_access", {31'b0, PENABLE}, 32'd1);
        #3 HRESETn = 1'b0;
        #1;
        chk("rstmid_psel", {31'b0, PSEL}, 32'd0);
        chk("rstmid_penable", {31'b0, PENABLE}, 32'd0);
        chk("rstmid_paddr", {20'b0, PADDR}, 32'd0);
        @(negedge HCLK); #3 HRESETn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge HCLK);
            chk("rstmid_no_rvalid", {31'b0, rvalid_o}, 32'd0);
        end
        run_xfer(1'b0, 12'h0C4, 32'h0, 1, 32'h0BAD_F00D, 1'b0, gw, lt, ac, rd, er, st, ps);
        chk("rstmid_next_latency", lt, 32'd4);
        chk("rstmid_next_rdata", rd, 32'h0BAD_F00D);

        // Random traffic, model-checked each cycle.
        gnt_seen = 0; stuck = 0;
        for (int c = 0; c < 800; c++) begin
            @(posedge HCLK); #1;
            if (!req_i || gnt_seen) begin
                req_i = ($urandom % 3) != 0;
                addr_i = AW'($urandom);
                we_i = 1'($urandom);
                wdata_i = $urandom;
                if (gnt_seen) stuck = ($urandom % 5) == 0;
            end
            PREADY = stuck ? 1'b0 : (($urandom % 3) == 0);
            PRDATA = $urandom;
            PSLVERR = ($urandom % 4) == 0;
            @(negedge HCLK);
            gnt_seen = gnt_o;
        end
        @(posedge HCLK); #1;
        req_i = 1'b0; PREADY = 1'b1;
        repeat (10) @(negedge HCLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
